// File: rtl/config_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : config_pkg                                         |
// | Description : Shared state type and default sizes for the        |
// |               configuration chain loader.                        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package config_pkg;

    localparam int c_CHAIN_LENGTH_DEF = 524;
    localparam int c_WORD_WIDTH_DEF   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : config_loader                                      |
// | Description : Serialises parallel words, MSB first, into a       |
// |               CHAIN_LENGTH-bit configuration shift chain.        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module config_loader
    import config_pkg::*;
#(
    parameter int CHAIN_LENGTH = c_CHAIN_LENGTH_DEF,
    parameter int WORD_WIDTH   = c_WORD_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_data,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done
);

    localparam int c_CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int c_IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WORD_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_IDX_W-1:0]    r_idx;
    logic [WORD_WIDTH-1:0] r_word;
    logic                  w_load;
    logic                  w_clear;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (word_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Chain length wins over word boundary: leftover word bits are dropped.
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_count == c_CNT_LAST) begin
                    w_state_next = ST_DONE;
                end else if (r_idx == c_IDX_LAST) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_count <= '0;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            if (w_clear) begin
                r_count <= '0;
            end
            if (w_load) begin
                r_word <= word_data;
                r_idx  <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_word  <= r_word << 1;
                r_idx   <= r_idx + 1'b1;
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Ready is withheld during abort so the producer never sees a dropped handshake.
    assign word_ready    = (r_state == ST_FETCH) && !abort;
    assign config_enable = (r_state == ST_SHIFT);
    assign config_data   = config_enable & r_word[WORD_WIDTH-1];
    assign busy          = (r_state == ST_FETCH) || (r_state == ST_SHIFT);
    assign done          = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The module SHALL have parameter CHAIN_LENGTH, default 524, giving the number of bits in the downstream configuration shift chain.
REQ-002 The module SHALL have parameter WORD_WIDTH, default 32, giving the parallel input word width.
REQ-003 Port clock, input, 1: single clock; all state updates occur on its rising edge.
REQ-004 Port nreset, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: single-cycle request to begin a chain load.
REQ-006 Port abort, input, 1: terminates any load in progress.
REQ-007 Port word_data, input, WORD_WIDTH: configuration word, transferred MSB first.
REQ-008 Port word_valid, input, 1: word_data holds a valid word.
REQ-009 Port word_ready, output, 1: the loader accepts a word this cycle.
REQ-010 Port config_data, output, 1: serial bit presented to the chain's data_in.
REQ-011 Port config_enable, output, 1: chain shift enable, with one bit consumed per high cycle.
REQ-012 Port busy, output, 1: a load is in progress.
REQ-013 Port done, output, 1: one-cycle pulse when exactly CHAIN_LENGTH bits have been shifted.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, SHIFT and DONE.
REQ-015 In IDLE, start=1 SHALL clear the bit counter and enter FETCH on the next cycle; in any other state, start SHALL be ignored.
REQ-016 In FETCH, word_ready SHALL be 1; a handshake (word_valid & word_ready) SHALL latch word_data and enter SHIFT; without word_valid the FSM SHALL stay in FETCH indefinitely.
REQ-017 word_ready SHALL be 0 in every state except FETCH.
REQ-018 In SHIFT, config_enable SHALL be 1 and config_data SHALL carry the latched word bits, MSB first, one bit per cycle, starting the cycle after the handshake.
REQ-019 The bit counter SHALL be $clog2(CHAIN_LENGTH+1) bits wide and SHALL increment on every SHIFT cycle.
REQ-020 After WORD_WIDTH SHIFT cycles, the FSM SHALL return to FETCH if the counter is below CHAIN_LENGTH.
REQ-021 When the counter reaches CHAIN_LENGTH, shifting SHALL stop immediately, mid-word if necessary, the unshifted low-order bits of that final word SHALL be discarded, and the FSM SHALL enter DONE.
REQ-022 For the defaults, the load SHALL use 17 words, and the final word SHALL contribute only its top 12 bits.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 busy SHALL be 1 in FETCH and SHIFT, and 0 in IDLE and DONE.
REQ-025 config_enable SHALL be 0 in IDLE, FETCH and DONE, so the chain never shifts between words.
REQ-026 config_data SHALL be 0 whenever config_enable is 0.
REQ-027 abort=1 in FETCH or SHIFT SHALL force IDLE on the next edge, with no done pulse, config_enable=0 from that edge, and no word accepted in that cycle.
REQ-028 abort SHALL take priority over start and over a same-cycle handshake.
REQ-029 Simultaneous start and abort in IDLE SHALL leave the FSM in IDLE.
REQ-030 With word_valid held at 1, a load SHALL take CHAIN_LENGTH + ceil(CHAIN_LENGTH/WORD_WIDTH) cycles from FETCH entry to DONE entry; for the defaults this is 541 cycles.

Reset
REQ-031 nreset=0 SHALL asynchronously force IDLE, a counter value of 0, a word register value of 0, and all outputs to 0.
REQ-032 Deassertion of nreset SHALL take effect on the next rising clock edge.
REQ-033 Reset asserted mid-load SHALL abandon the load with no done pulse.

Structure
REQ-034 The state enum and the default CHAIN_LENGTH and WORD_WIDTH constants SHALL reside in the shared package config_pkg.
REQ-035 The design SHALL be a single module with no sub-modules.
REQ-036 The word register, bit-within-word index and chain counter SHALL be internal to the module.

Verification
REQ-037 start at cycle 0, with word_valid=1 and 17 words of 0xFFFFFFFF -> done at cycle 542, exactly 524 config_enable cycles, and a connected 524-bit chain reading all ones.
REQ-038 Words 0x80000000 followed by 16 zero words -> chain bit 523=1 and all other chain bits 0.
REQ-039 word_valid low for 10 cycles before word 5 -> word_ready held high throughout, config_enable low in those cycles, and final chain contents unchanged.
REQ-040 abort at the 100th SHIFT cycle -> busy=0 and config_enable=0 on the next cycle, no done pulse, and a fresh start completes normally.
REQ-041 nreset pulsed low mid-SHIFT, asynchronously between edges -> all outputs 0 immediately, in IDLE, and start ignored until nreset is released.
REQ-042 start pulsed while busy, and start with abort in IDLE -> no effect on the load or count, and FSM stays in IDLE respectively.
